// File: rtl/spectro_frame_scanner.sv
// rtl/spectro_frame_scanner.sv - windowed pulse counter with snapshot and framed MSB-first serial dump
module spectro_frame_scanner #(
    parameter int         N_CH  = 15,
    parameter int         CNT_W = 12,
    parameter logic [3:0] SYNC  = 4'hA
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] ch_in,
    input  logic            rtc_in,
    input  logic            dump_req,
    input  logic [11:0]     period_s,
    input  logic            ser_ready,
    output logic            ser_out,
    output logic            ser_valid,
    output logic            ser_first,
    output logic            ser_last,
    output logic            busy,
    output logic            ovf_any,
    output logic [4:0]      word_idx
);

    localparam int               FRAME_W   = 28 + N_CH * CNT_W;
    localparam logic [4:0]       LAST_WORD = 5'(N_CH);
    localparam logic [4:0]       WORD_HDR  = 5'd31;
    localparam logic [4:0]       CNT_TOP   = 5'(CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR  = CNT_MAX - 1'b1;

    typedef enum logic [1:0] {IDLE, SNAP, HEADER, PAYLOAD} state_t;

    state_t                       state_q, state_d;
    logic [N_CH-1:0]              ch_meta_q, ch_sync_q, ch_prev_q;
    logic                         rtc_meta_q, rtc_sync_q, rtc_prev_q;
    logic [N_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0]              ovf_q, ovf_d;
    logic [5:0]                   sec_q, sec_d, min_q, min_d;
    logic                         rtc_ovf_q, rtc_ovf_d;
    logic [3:0]                   cause_q, cause_d, cause_c;
    logic [7:0]                   seq_q, seq_d;
    logic [FRAME_W-1:0]           frame_q, frame_d;
    logic [4:0]                   word_q, word_d, bit_q, bit_d;
    logic [N_CH-1:0]              ch_ev;
    logic                         rtc_ev, snap, accept;
    logic [11:0]                  elapsed;
    logic [N_CH*CNT_W-1:0]        pay;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ch_meta_q  <= '0;
            ch_sync_q  <= '0;
            ch_prev_q  <= '0;
            rtc_meta_q <= 1'b0;
            rtc_sync_q <= 1'b0;
            rtc_prev_q <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            rtc_ovf_q  <= 1'b0;
            cause_q    <= '0;
            seq_q      <= '0;
            frame_q    <= '0;
            word_q     <= WORD_HDR;
            bit_q      <= '0;
        end else begin
            state_q    <= state_d;
            ch_meta_q  <= ch_in;
            ch_sync_q  <= ch_meta_q;
            ch_prev_q  <= ch_sync_q;
            rtc_meta_q <= rtc_in;
            rtc_sync_q <= rtc_meta_q;
            rtc_prev_q <= rtc_sync_q;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            rtc_ovf_q  <= rtc_ovf_d;
            cause_q    <= cause_d;
            seq_q      <= seq_d;
            frame_q    <= frame_d;
            word_q     <= word_d;
            bit_q      <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|cause_c) state_d = SNAP;
            SNAP:    state_d = HEADER;
            HEADER:  if (accept && bit_q == 5'd0) state_d = PAYLOAD;
            PAYLOAD: if (accept && bit_q == 5'd0 && word_q == LAST_WORD) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        ser_valid = (state_q == HEADER) || (state_q == PAYLOAD);
        ser_out   = ser_valid & frame_q[FRAME_W-1];
        ser_first = (state_q == HEADER) && (bit_q == 5'd15);
        ser_last  = (state_q == PAYLOAD) && (word_q == LAST_WORD) && (bit_q == 5'd0);
        ovf_any   = (|ovf_q) | rtc_ovf_q;
        word_idx  = word_q;
    end

    always_comb begin
        ch_ev   = ch_sync_q & ~ch_prev_q;
        rtc_ev  = rtc_sync_q & ~rtc_prev_q;
        snap    = (state_q == SNAP);
        accept  = ser_valid & ser_ready;
        elapsed = 12'(min_q) * 12'd60 + 12'(sec_q);
        cause_c = {dump_req, (period_s != 12'd0) && (elapsed >= period_s), rtc_ovf_q, |ovf_q};

        // The live window restarts at SNAP, so an event in that same cycle counts from zero.
        cnt_d     = snap ? '0 : cnt_q;
        ovf_d     = snap ? '0 : ovf_q;
        sec_d     = snap ? '0 : sec_q;
        min_d     = snap ? '0 : min_q;
        rtc_ovf_d = snap ? 1'b0 : rtc_ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_ev[i] && cnt_d[i] != CNT_MAX) begin
                ovf_d[i] = ovf_d[i] | (cnt_d[i] == CNT_NEAR);
                cnt_d[i] = cnt_d[i] + 1'b1;
            end
        end
        if (rtc_ev) begin
            if (sec_d == 6'd59) begin
                sec_d = '0;
                if (min_d == 6'd63) begin
                    min_d     = '0;
                    rtc_ovf_d = 1'b1;
                end else begin
                    min_d = min_d + 6'd1;
                end
            end else begin
                sec_d = sec_d + 6'd1;
            end
        end

        cause_d = (state_q == IDLE) ? cause_c : cause_q;
        seq_d   = snap ? seq_q + 8'd1 : seq_q;

        pay = '0;
        for (int i = 0; i < N_CH; i++) begin
            pay[(N_CH-1-i)*CNT_W +: CNT_W] = cnt_q[i];
        end

        // frame_q doubles as the shadow copy: the whole record is latched at SNAP and shifted out.
        frame_d = frame_q;
        word_d  = word_q;
        bit_d   = bit_q;
        if (snap) begin
            frame_d = {SYNC, cause_q, seq_q, min_q, sec_q, pay};
            word_d  = WORD_HDR;
            bit_d   = 5'd15;
        end else if (accept) begin
            frame_d = frame_q << 1;
            if (bit_q != 5'd0) begin
                bit_d = bit_q - 5'd1;
            end else if (state_q == HEADER) begin
                word_d = 5'd0;
                bit_d  = 5'd11;
            end else if (word_q == LAST_WORD) begin
                word_d = WORD_HDR;
            end else begin
                word_d = word_q + 5'd1;
                bit_d  = CNT_TOP;
            end
        end
    end

endmodule

// File: tb/tb_spectro_frame_scanner.sv
// tb/tb_spectro_frame_scanner.sv - self-checking bench for spectro_frame_scanner
module tb_spectro_frame_scanner;

    localparam int N_CH  = 15;
    localparam int CNT_W = 12;
    localparam int FW    = 28 + N_CH * CNT_W;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N_CH-1:0] ch_in = '0;
    logic            rtc_in = 1'b0;
    logic            dump_req = 1'b0;
    logic [11:0]     period_s = '0;
    logic            ser_ready = 1'b1;
    logic            ser_out, ser_valid, ser_first, ser_last, busy, ovf_any;
    logic [4:0]      word_idx;
    logic            rand_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spectro_frame_scanner #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC(4'hA)) dut (
        .clk(clk), .reset(reset), .ch_in(ch_in), .rtc_in(rtc_in), .dump_req(dump_req),
        .period_s(period_s), .ser_ready(ser_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_first(ser_first), .ser_last(ser_last), .busy(busy), .ovf_any(ovf_any),
        .word_idx(word_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: live window as plain counts, elapsed seconds as one integer, frame as a bit queue.
    int              live[N_CH];
    bit              ovf_m[N_CH];
    int              secs = 0;
    bit              rtc_ovf_m = 0;
    int              mode = 0;
    bit [3:0]        cause_m = 0;
    bit [7:0]        seq_m = 0;
    bit              exp_q[$];
    int              pos = 0;
    logic [N_CH-1:0] p1 = '0, p2 = '0, p3 = '0;
    logic            r1 = 0, r2 = 0, r3 = 0;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            live[i]  = 0;
            ovf_m[i] = 0;
        end
        secs = 0; rtc_ovf_m = 0; mode = 0; cause_m = 0; seq_m = 0; pos = 0;
        exp_q.delete();
        p1 = '0; p2 = '0; p3 = '0; r1 = 0; r2 = 0; r3 = 0;
    endtask

    task automatic model_step();
        logic [N_CH-1:0] ev;
        logic            rev;
        logic [3:0]      c;
        logic [FW-1:0]   v;
        ev = p2 & ~p3;
        rev = r2 & ~r3;
        p3 = p2; p2 = p1; p1 = ch_in;
        r3 = r2; r2 = r1; r1 = rtc_in;
        case (mode)
            0: begin
                c[3] = dump_req;
                c[2] = (period_s != 0) && (secs >= int'(period_s));
                c[1] = rtc_ovf_m;
                c[0] = 1'b0;
                for (int i = 0; i < N_CH; i++) c[0] = c[0] | ovf_m[i];
                if (c != 0) begin
                    cause_m = c;
                    mode = 1;
                end
            end
            1: begin
                v = '0;
                v[FW-1 -: 4]  = 4'hA;
                v[FW-5 -: 4]  = cause_m;
                v[FW-9 -: 8]  = seq_m;
                v[FW-17 -: 6] = 6'(secs / 60);
                v[FW-23 -: 6] = 6'(secs % 60);
                for (int i = 0; i < N_CH; i++) v[FW-29-i*CNT_W -: CNT_W] = CNT_W'(live[i]);
                for (int b = FW - 1; b >= 0; b--) exp_q.push_back(v[b]);
                seq_m = seq_m + 8'd1;
                pos = 0;
                mode = 2;
                for (int i = 0; i < N_CH; i++) begin
                    live[i] = 0;
                    ovf_m[i] = 0;
                end
                secs = 0;
                rtc_ovf_m = 0;
            end
            default: begin
                if (ser_ready) begin
                    void'(exp_q.pop_front());
                    pos++;
                    if (exp_q.size() == 0) mode = 0;
                end
            end
        endcase
        for (int i = 0; i < N_CH; i++) begin
            if (ev[i] && live[i] < MAXC) begin
                live[i]++;
                if (live[i] == MAXC) ovf_m[i] = 1;
            end
        end
        if (rev) begin
            secs++;
            if (secs == 64 * 60) begin
                secs = 0;
                rtc_ovf_m = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    initial begin
        logic [10:0] got, exp;
        logic        ev_valid, any_ovf;
        int          widx;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                ev_valid = (mode == 2);
                any_ovf = rtc_ovf_m;
                for (int i = 0; i < N_CH; i++) any_ovf = any_ovf | ovf_m[i];
                if (!ev_valid || pos < 16) widx = 31;
                else if (pos < 28) widx = 0;
                else widx = 1 + (pos - 28) / CNT_W;
                exp = {ev_valid, ev_valid ? exp_q[0] : 1'b0, ev_valid && pos == 0,
                       ev_valid && exp_q.size() == 1, mode != 0, any_ovf, 5'(widx)};
                got = {ser_valid, ser_out, ser_first, ser_last, busy, ovf_any, word_idx};
                check("cycle_outputs{valid,out,first,last,busy,ovf,widx}", 32'(got), 32'(exp));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            ser_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [FW-1:0] cur = '0;
    int            cur_n = 0;
    logic [FW-1:0] frames[$];
    int            lens[$];

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                cur_n = 0;
            end else if (ser_valid && ser_ready) begin
                if (ser_first) cur_n = 0;
                cur = {cur[FW-2:0], ser_out};
                cur_n++;
                if (ser_last) begin
                    frames.push_back(cur);
                    lens.push_back(cur_n);
                end
            end
        end
    end

    function automatic logic [15:0] f_hdr(input logic [FW-1:0] f);
        return f[FW-1 -: 16];
    endfunction

    function automatic logic [11:0] f_ts(input logic [FW-1:0] f);
        return f[FW-17 -: 12];
    endfunction

    function automatic logic [CNT_W-1:0] f_ch(input logic [FW-1:0] f, input int i);
        return f[FW-29-(i-1)*CNT_W -: CNT_W];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_ch(input int idx, input int n);
        repeat (n) begin
            ch_in[idx] = 1'b1; tick();
            ch_in[idx] = 1'b0; tick();
        end
    endtask

    task automatic rtc_pulses(input int n);
        repeat (n) begin
            rtc_in = 1'b1; tick();
            rtc_in = 1'b0; tick();
        end
    endtask

    task automatic dump();
        dump_req = 1'b1; tick();
        dump_req = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int c = 0;
        while (frames.size() < n && c < 6000) begin
            tick();
            c++;
        end
        check("frame_count", 32'(frames.size()), 32'(n));
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 6000) begin
            tick();
            c++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int c;
        int nf;
        repeat (3) tick();
        check("reset_outputs", 32'({ser_out, ser_valid, ser_first, ser_last, busy, ovf_any}), 32'd0);
        check("reset_word_idx", 32'(word_idx), 32'd31);
        reset = 1'b1;
        repeat (2) tick();

        pulse_ch(2, 5);
        pulse_ch(14, 2);
        repeat (4) tick();
        dump();
        wait_frames(1);
        wait_idle();
        check("f0_len", 32'(lens[0]), 32'd208);
        check("f0_hdr", 32'(f_hdr(frames[0])), 32'hA800);
        check("f0_ts", 32'(f_ts(frames[0])), 32'h000);
        check("f0_ch3", 32'(f_ch(frames[0], 3)), 32'h005);
        check("f0_ch15", 32'(f_ch(frames[0], 15)), 32'h002);
        check("f0_ch1", 32'(f_ch(frames[0], 1)), 32'h000);

        pulse_ch(0, MAXC);
        c = 0;
        while (!ovf_any && c < 20) begin
            tick();
            c++;
        end
        check("sat_ovf_any", 32'(ovf_any), 32'd1);
        wait_frames(2);
        wait_idle();
        check("f1_hdr", 32'(f_hdr(frames[1])), 32'hA101);
        check("f1_ch1", 32'(f_ch(frames[1], 1)), 32'hFFF);
        dump();
        wait_frames(3);
        wait_idle();
        check("f2_hdr", 32'(f_hdr(frames[2])), 32'hA802);
        check("f2_ch1_live_cleared", 32'(f_ch(frames[2], 1)), 32'h000);

        period_s = 12'd3;
        rtc_pulses(3);
        wait_frames(4);
        wait_idle();
        check("f3_hdr", 32'(f_hdr(frames[3])), 32'hA403);
        check("f3_ts", 32'(f_ts(frames[3])), 32'h003);
        period_s = 12'd0;
        rtc_pulses(200);
        repeat (5) tick();
        check("period_off_no_frame", 32'(frames.size()), 32'd4);
        dump();
        wait_frames(5);
        wait_idle();
        check("f4_hdr", 32'(f_hdr(frames[4])), 32'hA804);
        check("f4_ts_3m20s", 32'(f_ts(frames[4])), 32'h0D4);

        rtc_pulses(64 * 60);
        wait_frames(6);
        wait_idle();
        check("f5_hdr", 32'(f_hdr(frames[5])), 32'hA205);
        check("f5_ts", 32'(f_ts(frames[5])), 32'h000);

        rand_ready = 1'b1;
        pulse_ch(1, 3);
        repeat (4) tick();
        ch_in[1] = 1'b1; tick();
        ch_in[1] = 1'b0; dump_req = 1'b1; tick();
        dump_req = 1'b0;
        wait_frames(7);
        wait_idle();
        dump();
        wait_frames(8);
        wait_idle();
        check("f6_hdr", 32'(f_hdr(frames[6])), 32'hA806);
        check("f6_ch2", 32'(f_ch(frames[6], 2)), 32'h003);
        check("f7_hdr", 32'(f_hdr(frames[7])), 32'hA807);
        check("f7_ch2_snap_pulse", 32'(f_ch(frames[7], 2)), 32'h001);

        period_s = 12'd7;
        for (int k = 0; k < 3000; k++) begin
            ch_in = N_CH'($urandom);
            rtc_in = 1'($urandom);
            dump_req = ($urandom_range(0, 19) == 0);
            tick();
        end
        ch_in = '0; rtc_in = 1'b0; dump_req = 1'b0; period_s = 12'd0;
        rand_ready = 1'b0;
        repeat (5) tick();
        wait_idle();
        repeat (3) tick();
        wait_idle();

        pulse_ch(4, 2);
        repeat (4) tick();
        dump();
        c = 0;
        while (!(ser_valid && word_idx != 5'd31 && word_idx >= 5'd2) && c < 2000) begin
            tick();
            c++;
        end
        check("reached_payload", 32'(ser_valid && word_idx != 5'd31 && word_idx >= 5'd2), 32'd1);
        nf = frames.size();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", 32'({ser_out, ser_valid, ser_first, ser_last, busy, ovf_any}), 32'd0);
        check("async_reset_word_idx", 32'(word_idx), 32'd31);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        dump();
        wait_frames(nf + 1);
        wait_idle();
        check("post_reset_hdr", 32'(f_hdr(frames[nf])), 32'hA800);
        check("post_reset_ch5", 32'(f_ch(frames[nf], 5)), 32'h000);

        foreach (lens[i]) check("frame_len", 32'(lens[i]), 32'(FW));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
